la_trigger_ctrl: RTL

Trigger and capture-qualification stage upstream of the logic-analyzer sample memory. Watches a 72-bit probe bus and drives the memory's write interface (`capture_data`, `capture_trigger`, `capture_enable`, `capture_reset`). On arm it streams samples continuously into the wrapping capture memory as pre-trigger history. When a masked pattern match occurs it captures a programmed number of post-trigger samples, then freezes the memory for software readout. It reports the memory address holding the trigger sample.

---
 rtl/la_pkg.sv | 20 ++
 rtl/la_trigger_match.sv | 55 +++++
 rtl/la_trigger_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/la_pkg.sv
// Shared constants and types for the logic-analyzer trigger controller.
package la_pkg;

   // Default geometry of the downstream capture memory and the probe bus.
   localparam int LA_ADDR_WIDTH = 10;
   localparam int LA_DATA_WIDTH = 72;

   // Trigger qualification modes.
   localparam logic TRIG_MODE_LEVEL  = 1'b0;
   localparam logic TRIG_MODE_RISING = 1'b1;

   // Controller states; the encoding is visible on the state output.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ARMED     = 2'd1,
      ST_TRIGGERED = 2'd2,
      ST_DONE      = 2'd3
   } la_state_e;

endpackage : la_pkg

// File: rtl/la_trigger_match.sv
// Masked pattern comparator with optional rising-edge qualification.
// trig_hit is combinational so the trigger is evaluated on the same cycle
// as the sample that carries it.
module la_trigger_match
   import la_pkg::*;
#(
   parameter int DATA_WIDTH = LA_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  trig_mode,
   input  logic [DATA_WIDTH-1:0] trig_value,
   input  logic [DATA_WIDTH-1:0] trig_mask,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  trig_hit
);

   logic pattern_eq_s;
   logic match_s;
   logic prev_match_r;

   // Compare the masked sample against the pattern and qualify by mode.
   always_comb begin
      pattern_eq_s = 1'b0;
      match_s      = 1'b0;
      trig_hit     = 1'b0;
      if (((in_data ^ trig_value) & trig_mask) == {DATA_WIDTH{1'b0}}) begin
         pattern_eq_s = 1'b1;
      end else begin
         pattern_eq_s = 1'b0;
      end
      match_s = in_valid & pattern_eq_s;
      if (trig_mode == TRIG_MODE_RISING) begin
         trig_hit = match_s & ~prev_match_r;
      end else begin
         trig_hit = match_s;
      end
   end

   // Remember the match result of the last valid sample; cleared on arming.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_match_r <= 1'b0;
      end else if (clear) begin
         prev_match_r <= 1'b0;
      end else if (in_valid) begin
         prev_match_r <= pattern_eq_s;
      end else begin
         prev_match_r <= prev_match_r;
      end
   end

endmodule : la_trigger_match

// File: rtl/la_trigger_ctrl.sv
// Trigger/capture qualification FSM feeding the wrapping sample memory.
// sample_cnt mirrors the downstream write pointer, so the value it holds
// when the trigger sample is accepted is that sample's memory address.
module la_trigger_ctrl
   import la_pkg::*;
#(
   parameter int ADDR_WIDTH = LA_ADDR_WIDTH,
   parameter int DATA_WIDTH = LA_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  arm,
   input  logic                  abort,
   input  logic                  trig_mode,
   input  logic [DATA_WIDTH-1:0] trig_value,
   input  logic [DATA_WIDTH-1:0] trig_mask,
   input  logic [ADDR_WIDTH-1:0] post_count,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic [DATA_WIDTH-1:0] capture_data,
   output logic                  capture_trigger,
   output logic                  capture_enable,
   output logic                  capture_reset,
   output logic [1:0]            state,
   output logic [ADDR_WIDTH-1:0] trig_addr,
   output logic                  wrapped,
   output logic                  done
);

   la_state_e             state_r;
   logic [ADDR_WIDTH-1:0] sample_cnt_r;
   logic [ADDR_WIDTH-1:0] remaining_r;
   logic [ADDR_WIDTH-1:0] trig_addr_r;
   logic                  wrapped_r;
   logic                  done_r;
   logic [DATA_WIDTH-1:0] capture_data_r;
   logic                  capture_trigger_r;
   logic                  capture_enable_r;
   logic                  capture_reset_r;

   logic                  accept_s;
   logic                  arm_start_s;
   logic                  trig_hit_s;
   logic                  cnt_max_s;
   logic                  remaining_last_s;
   logic                  post_zero_s;
   logic [ADDR_WIDTH-1:0] cnt_next_s;

   la_trigger_match #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_match (
      .clk        (clk),
      .reset      (reset),
      .clear      (arm_start_s),
      .trig_mode  (trig_mode),
      .trig_value (trig_value),
      .trig_mask  (trig_mask),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .trig_hit   (trig_hit_s)
   );

   // Decode sample acceptance, arming and counter boundary conditions.
   always_comb begin
      accept_s         = 1'b0;
      arm_start_s      = 1'b0;
      cnt_max_s        = 1'b0;
      remaining_last_s = 1'b0;
      post_zero_s      = 1'b0;
      cnt_next_s       = sample_cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      if (((state_r == ST_ARMED) || (state_r == ST_TRIGGERED)) && in_valid && !abort) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
      if (((state_r == ST_IDLE) || (state_r == ST_DONE)) && arm && !abort) begin
         arm_start_s = 1'b1;
      end else begin
         arm_start_s = 1'b0;
      end
      if (sample_cnt_r == {ADDR_WIDTH{1'b1}}) begin
         cnt_max_s = 1'b1;
      end else begin
         cnt_max_s = 1'b0;
      end
      if (remaining_r == {{(ADDR_WIDTH-1){1'b0}}, 1'b1}) begin
         remaining_last_s = 1'b1;
      end else begin
         remaining_last_s = 1'b0;
      end
      if (post_count == {ADDR_WIDTH{1'b0}}) begin
         post_zero_s = 1'b1;
      end else begin
         post_zero_s = 1'b0;
      end
   end

   // Capture FSM, write-pointer mirror and registered memory interface.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r           <= ST_IDLE;
         sample_cnt_r      <= {ADDR_WIDTH{1'b0}};
         remaining_r       <= {ADDR_WIDTH{1'b0}};
         trig_addr_r       <= {ADDR_WIDTH{1'b0}};
         wrapped_r         <= 1'b0;
         done_r            <= 1'b0;
         capture_data_r    <= {DATA_WIDTH{1'b0}};
         capture_trigger_r <= 1'b0;
         capture_enable_r  <= 1'b0;
         capture_reset_r   <= 1'b0;
      end else begin
         // Memory strobes follow the accepted sample by one cycle; the
         // pointer clear lands on the first ARMED cycle, before any write.
         capture_trigger_r <= accept_s;
         capture_enable_r  <= accept_s;
         capture_reset_r   <= arm_start_s;
         if (accept_s) begin
            capture_data_r <= in_data;
            sample_cnt_r   <= cnt_next_s;
         end else begin
            capture_data_r <= capture_data_r;
            sample_cnt_r   <= sample_cnt_r;
         end

         case (state_r)
            ST_IDLE, ST_DONE: begin
               if (abort) begin
                  state_r <= ST_IDLE;
                  done_r  <= 1'b0;
               end else if (arm) begin
                  state_r      <= ST_ARMED;
                  done_r       <= 1'b0;
                  sample_cnt_r <= {ADDR_WIDTH{1'b0}};
                  wrapped_r    <= 1'b0;
               end else begin
                  state_r <= state_r;
                  done_r  <= (state_r == ST_DONE);
               end
            end
            ST_ARMED: begin
               if (abort) begin
                  state_r <= ST_IDLE;
                  done_r  <= 1'b0;
               end else if (accept_s) begin
                  if (cnt_max_s) begin
                     wrapped_r <= 1'b1;
                  end else begin
                     wrapped_r <= wrapped_r;
                  end
                  if (trig_hit_s) begin
                     trig_addr_r <= sample_cnt_r;
                     remaining_r <= post_count;
                     if (post_zero_s) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                     end else begin
                        state_r <= ST_TRIGGERED;
                        done_r  <= 1'b0;
                     end
                  end else begin
                     state_r <= ST_ARMED;
                     done_r  <= 1'b0;
                  end
               end else begin
                  state_r <= ST_ARMED;
                  done_r  <= 1'b0;
               end
            end
            ST_TRIGGERED: begin
               if (abort) begin
                  state_r <= ST_IDLE;
                  done_r  <= 1'b0;
               end else if (accept_s) begin
                  remaining_r <= remaining_r - {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                  if (remaining_last_s) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= ST_TRIGGERED;
                     done_r  <= 1'b0;
                  end
               end else begin
                  state_r <= ST_TRIGGERED;
                  done_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign state           = state_r;
   assign trig_addr       = trig_addr_r;
   assign wrapped         = wrapped_r;
   assign done            = done_r;
   assign capture_data    = capture_data_r;
   assign capture_trigger = capture_trigger_r;
   assign capture_enable  = capture_enable_r;
   assign capture_reset   = capture_reset_r;

endmodule : la_trigger_ctrl
